tcam_rule_cfg_ctrl: RTL and testbench
=====================================

// Module: tcam_rule_cfg_ctrl
// PURPOSE
//  Host-side configuration sequencer for the dispatcher TCAM. Decodes AXI-lite register-interface
//  accesses into staged rule fields, then drives the TCAM set_* port: single-entry write, single-entry
//  clear, clear-all. Runs clear-all automatically after reset and flags end_init_tcam for the dispatcher FSM.
// PARAMETERS
//  TCAM_ADDR_WIDTH  4   TCAM entry index width (2**W entries)
//  TCAM_KEY_WIDTH   48  key / xmask width (<=64)
//  TCAM_DATA_WIDTH  2   result width (= AXIS_DEST_WIDTH, <=32)
//  REG_ADDR_WIDTH   16  register address width
//  REG_DATA_WIDTH   32  register data width (fixed 32)
//  REG_STRB_WIDTH   4   REG_DATA_WIDTH/8
//  BASE_ADDR        0   block base; registers at BASE_ADDR+0x00..0x1C
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   async active-low reset
//  reg_wr_addr    in   REG_ADDR_WIDTH   write address
//  reg_wr_data    in   32  write data
//  reg_wr_strb    in   REG_STRB_WIDTH   byte strobes
//  reg_wr_en      in   1   write request
//  reg_wr_wait    out  1   write stalled
//  reg_wr_ack     out  1   write complete
//  reg_rd_addr    in   REG_ADDR_WIDTH   read address
//  reg_rd_en      in   1   read request
//  reg_rd_data    out  32  read data
//  reg_rd_wait    out  1   read stalled (always 0)
//  reg_rd_ack     out  1   read complete
//  set_addr/set_data/set_key/set_xmask  out  ADDR/DATA/KEY/KEY widths  TCAM write fields
//  set_clr        out  1   entry clear qualifier
//  set_valid      out  1   TCAM write strobe, one entry per cycle
//  cfg_busy       out  1   sequence in progress; dispatcher holds lookups
//  end_init_tcam  out  1   post-reset clear-all done (sticky until reset)
// BEHAVIOUR
//  Registers (offset, byte strobes honoured on all RW regs):
//   0x00 CTRL  WO: b0 COMMIT, b1 CLR_ENTRY, b2 CLR_ALL; reads 0
//   0x04 STAT  RO: b0 busy, b1 init_done, b31:16 commit_cnt
//   0x08 ADDR  RW[ADDR-1:0]   0x0C DATA RW[DATA-1:0]
//   0x10 KEY_LO RW  0x14 KEY_HI RW[KEY-33:0]   0x18 XMASK_LO RW  0x1C XMASK_HI RW
//   Unmapped addresses: write acked and ignored; read returns 0.
//  Reset: all outputs 0; staging registers and commit_cnt 0; FSM enters INIT_CLR.
//  FSM:
//   INIT_CLR: set_valid=1, set_clr=1, set_addr = idx 0..2**W-1, one per cycle.
//             After last idx: end_init_tcam<=1, go to IDLE.
//   IDLE: accepts CTRL writes. Priority CLR_ALL > CLR_ENTRY > COMMIT.
//         CLR_ALL goes to CLR_ALL; others go to ISSUE.
//   ISSUE: one cycle, set_valid=1 with the staged fields latched at CTRL write.
//          set_clr=1 only for CLR_ENTRY. commit_cnt++ (wraps at 0xFFFF) on COMMIT only.
//          Returns to IDLE.
//   CLR_ALL: same as INIT_CLR; end_init_tcam unchanged. Returns to IDLE.
//  Latency: CTRL write accepted in cycle N -> reg_wr_ack in N+1, set_valid in N+1.
//  Clear-all takes 2**W cycles.
//  cfg_busy = (state != IDLE).
//  Handshake:
//   - Non-CTRL writes and all reads: ack one cycle after en, no wait, in any state.
//   - CTRL write while busy: reg_wr_wait=1 until IDLE, then accepted as above.
//   - en must stay high while wait=1.
//  Staging-register writes during ISSUE do not affect the entry being issued.
//  Simultaneous read and write are both served in the same cycle.
//  rst_n low mid-sequence aborts at once: outputs 0, end_init_tcam 0, INIT_CLR restarts on release.
//  set_* fields outside set_valid cycles hold their last value; set_clr=0 outside set_valid.
// TESTING
//  T1 reset release, W=4 -> 16 cycles of set_valid&set_clr, addr 0..15; then end_init_tcam=1, cfg_busy=0.
//  T2 ADDR=3, DATA=2, KEY_LO=0xC0A80001, KEY_HI=0x0800, CTRL=1 ->
//     next cycle set_valid=1, set_addr=3, set_data=2, set_key=0x0800C0A80001, set_clr=0; STAT[31:16]=1.
//  T3 CTRL=4 then CTRL=1 next cycle -> second write waits 16 cycles (wait=1), then issues once;
//     commit_cnt increments by 1.
//  T4 CTRL=0x7 in IDLE -> clear-all only, commit_cnt unchanged.
//  T5 KEY_LO write, strb=4'b0011, data 0xFFFFFFFF over 0x12345678 -> KEY_LO reads 0x1234FFFF.
//  T6 rst_n low at clear-all idx 7 -> outputs 0 at once; after release full INIT_CLR from idx 0.

Source files
------------

// File: rtl/tcam_rule_cfg_ctrl.sv
// Host-side configuration sequencer for the dispatcher TCAM: register file staging of rule
// fields plus an FSM that issues single-entry writes/clears and clear-all sweeps.
module tcam_rule_cfg_ctrl #(
    parameter int TCAM_ADDR_WIDTH = 4,
    parameter int TCAM_KEY_WIDTH  = 48,
    parameter int TCAM_DATA_WIDTH = 2,
    parameter int REG_ADDR_WIDTH  = 16,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_STRB_WIDTH  = 4,
    parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0]  reg_wr_data,
    input  logic [REG_STRB_WIDTH-1:0]  reg_wr_strb,
    input  logic                       reg_wr_en,
    output logic                       reg_wr_wait,
    output logic                       reg_wr_ack,
    input  logic [REG_ADDR_WIDTH-1:0]  reg_rd_addr,
    input  logic                       reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0]  reg_rd_data,
    output logic                       reg_rd_wait,
    output logic                       reg_rd_ack,
    output logic [TCAM_ADDR_WIDTH-1:0] set_addr,
    output logic [TCAM_DATA_WIDTH-1:0] set_data,
    output logic [TCAM_KEY_WIDTH-1:0]  set_key,
    output logic [TCAM_KEY_WIDTH-1:0]  set_xmask,
    output logic                       set_clr,
    output logic                       set_valid,
    output logic                       cfg_busy,
    output logic                       end_init_tcam
);

    typedef enum logic [1:0] {
        ST_INIT_CLR = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_CLR_ALL  = 2'd3
    } state_t;

    localparam logic [TCAM_ADDR_WIDTH-1:0] LAST_IDX = {TCAM_ADDR_WIDTH{1'b1}};
    localparam logic [63:0] KEY_MASK = (TCAM_KEY_WIDTH >= 64) ? {64{1'b1}} :
                                       ((64'd1 << TCAM_KEY_WIDTH) - 64'd1);
    localparam logic [REG_ADDR_WIDTH-1:0] MAP_SIZE = REG_ADDR_WIDTH'(32'h20);

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [REG_STRB_WIDTH-1:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < REG_STRB_WIDTH; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t                       state_r;
    logic [TCAM_ADDR_WIDTH-1:0]   stg_addr_r;
    logic [TCAM_DATA_WIDTH-1:0]   stg_data_r;
    logic [63:0]                  stg_key_r;
    logic [63:0]                  stg_xmask_r;
    logic [15:0]                  commit_cnt_r;

    logic [REG_ADDR_WIDTH-1:0]    wr_off_s;
    logic [REG_ADDR_WIDTH-1:0]    rd_off_s;
    logic                         wr_hit_s;
    logic                         rd_hit_s;
    logic [2:0]                   wr_idx_s;
    logic [2:0]                   rd_idx_s;
    logic                         wr_ctrl_s;
    logic [2:0]                   ctrl_cmd_s;
    logic [31:0]                  rd_val_s;
    logic                         unused_bits_s;

    assign wr_off_s      = reg_wr_addr - BASE_ADDR;
    assign rd_off_s      = reg_rd_addr - BASE_ADDR;
    assign wr_hit_s      = (wr_off_s < MAP_SIZE);
    assign rd_hit_s      = (rd_off_s < MAP_SIZE);
    assign wr_idx_s      = wr_off_s[4:2];
    assign rd_idx_s      = rd_off_s[4:2];
    assign reg_rd_wait   = 1'b0;
    assign unused_bits_s = ^{wr_off_s[1:0], rd_off_s[1:0]};

    // Write-side decode: CTRL writes stall while a sequence runs, everything else flows through.
    always_comb begin
        wr_ctrl_s   = reg_wr_en && wr_hit_s && (wr_idx_s == 3'd0);
        reg_wr_wait = wr_ctrl_s && (state_r != ST_IDLE);
        if (wr_ctrl_s && (state_r == ST_IDLE)) begin
            ctrl_cmd_s = reg_wr_data[2:0] & {3{reg_wr_strb[0]}};
        end else begin
            ctrl_cmd_s = 3'b000;
        end
    end

    // Read-side register mux.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (rd_hit_s) begin
            case (rd_idx_s)
                3'd1:    rd_val_s = {commit_cnt_r, 14'd0, end_init_tcam, cfg_busy};
                3'd2:    rd_val_s = 32'(stg_addr_r);
                3'd3:    rd_val_s = 32'(stg_data_r);
                3'd4:    rd_val_s = stg_key_r[31:0];
                3'd5:    rd_val_s = stg_key_r[63:32];
                3'd6:    rd_val_s = stg_xmask_r[31:0];
                3'd7:    rd_val_s = stg_xmask_r[63:32];
                default: rd_val_s = 32'h0000_0000;
            endcase
        end else begin
            rd_val_s = 32'h0000_0000;
        end
    end

    // Register-interface acknowledges and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_ack  <= 1'b0;
            reg_rd_ack  <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            reg_wr_ack  <= reg_wr_en && !reg_wr_wait;
            reg_rd_ack  <= reg_rd_en;
            reg_rd_data <= reg_rd_en ? rd_val_s : 32'h0000_0000;
        end
    end

    // Staging registers; bits beyond the configured widths never hold ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_addr_r  <= '0;
            stg_data_r  <= '0;
            stg_key_r   <= 64'd0;
            stg_xmask_r <= 64'd0;
        end else if (reg_wr_en && wr_hit_s) begin
            case (wr_idx_s)
                3'd2: stg_addr_r  <= TCAM_ADDR_WIDTH'(apply_strb(32'(stg_addr_r), reg_wr_data, reg_wr_strb));
                3'd3: stg_data_r  <= TCAM_DATA_WIDTH'(apply_strb(32'(stg_data_r), reg_wr_data, reg_wr_strb));
                3'd4: stg_key_r   <= {stg_key_r[63:32], apply_strb(stg_key_r[31:0], reg_wr_data, reg_wr_strb)} & KEY_MASK;
                3'd5: stg_key_r   <= {apply_strb(stg_key_r[63:32], reg_wr_data, reg_wr_strb), stg_key_r[31:0]} & KEY_MASK;
                3'd6: stg_xmask_r <= {stg_xmask_r[63:32], apply_strb(stg_xmask_r[31:0], reg_wr_data, reg_wr_strb)} & KEY_MASK;
                3'd7: stg_xmask_r <= {apply_strb(stg_xmask_r[63:32], reg_wr_data, reg_wr_strb), stg_xmask_r[31:0]} & KEY_MASK;
                default: stg_addr_r <= stg_addr_r;
            endcase
        end else begin
            stg_addr_r <= stg_addr_r;
        end
    end

    // Sequencer FSM; set_* are loaded on the edge entering a state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_INIT_CLR;
            set_addr      <= '0;
            set_data      <= '0;
            set_key       <= '0;
            set_xmask     <= '0;
            set_clr       <= 1'b0;
            set_valid     <= 1'b0;
            cfg_busy      <= 1'b0;
            end_init_tcam <= 1'b0;
            commit_cnt_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_INIT_CLR, ST_CLR_ALL: begin
                    cfg_busy <= 1'b1;
                    if (!set_valid) begin
                        // first cycle after reset release: sweep not yet started
                        set_valid <= 1'b1;
                        set_clr   <= 1'b1;
                        set_addr  <= '0;
                    end else if (set_addr == LAST_IDX) begin
                        set_valid <= 1'b0;
                        set_clr   <= 1'b0;
                        cfg_busy  <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (state_r == ST_INIT_CLR) begin
                            end_init_tcam <= 1'b1;
                        end else begin
                            end_init_tcam <= end_init_tcam;
                        end
                    end else begin
                        set_addr <= set_addr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (ctrl_cmd_s[2]) begin
                        state_r   <= ST_CLR_ALL;
                        set_valid <= 1'b1;
                        set_clr   <= 1'b1;
                        set_addr  <= '0;
                        cfg_busy  <= 1'b1;
                    end else if (ctrl_cmd_s[1] || ctrl_cmd_s[0]) begin
                        state_r   <= ST_ISSUE;
                        set_valid <= 1'b1;
                        set_clr   <= ctrl_cmd_s[1];
                        set_addr  <= stg_addr_r;
                        set_data  <= stg_data_r;
                        set_key   <= stg_key_r[TCAM_KEY_WIDTH-1:0];
                        set_xmask <= stg_xmask_r[TCAM_KEY_WIDTH-1:0];
                        cfg_busy  <= 1'b1;
                        if (!ctrl_cmd_s[1]) begin
                            commit_cnt_r <= commit_cnt_r + 16'd1;
                        end else begin
                            commit_cnt_r <= commit_cnt_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    set_valid <= 1'b0;
                    set_clr   <= 1'b0;
                    cfg_busy  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    set_valid <= 1'b0;
                    set_clr   <= 1'b0;
                    cfg_busy  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_rule_cfg_ctrl.sv
// Self-checking bench for tcam_rule_cfg_ctrl: directed scenarios plus randomized register
// traffic checked against a word-level model of the register map and TCAM write port.
module tb_tcam_rule_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en;
    logic        reg_wr_wait;
    logic        reg_wr_ack;
    logic [15:0] reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_wait;
    logic        reg_rd_ack;
    logic [3:0]  set_addr;
    logic [1:0]  set_data;
    logic [47:0] set_key;
    logic [47:0] set_xmask;
    logic        set_clr;
    logic        set_valid;
    logic        cfg_busy;
    logic        end_init_tcam;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mregs [8];
    logic [15:0] mcnt;

    tcam_rule_cfg_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
        .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
        .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
        .set_addr(set_addr), .set_data(set_data), .set_key(set_key), .set_xmask(set_xmask),
        .set_clr(set_clr), .set_valid(set_valid), .cfg_busy(cfg_busy), .end_init_tcam(end_init_tcam)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rw_mask(input int idx);
        case (idx)
            2: return 32'h0000_000F;
            3: return 32'h0000_0003;
            5, 7: return 32'h0000_FFFF;
            4, 6: return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) bm[8*b +: 8] = 8'hFF;
        if (idx >= 2 && idx <= 7) mregs[idx] = ((mregs[idx] & ~bm) | (d & bm)) & rw_mask(idx);
    endtask

    function automatic logic [31:0] model_read(input int idx);
        if (idx == 1) return {mcnt, 14'd0, 1'b1, 1'b0};
        if (idx >= 2 && idx <= 7) return mregs[idx];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0;
        mcnt = 16'd0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output int waits);
        reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
        #1;
        waits = 0;
        while (reg_wr_wait === 1'b1 && waits < 100) begin
            @(posedge clk); #2;
            waits++;
        end
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
        chk("wr_ack", 64'(reg_wr_ack), 64'd1);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        reg_rd_addr = a; reg_rd_en = 1'b1;
        @(posedge clk); #1;
        reg_rd_en = 1'b0;
        chk("rd_ack", 64'(reg_rd_ack), 64'd1);
        d = reg_rd_data;
    endtask

    task automatic sweep_check(input string tag, input logic exp_init);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_valid"}, 64'(set_valid), 64'd1);
            chk({tag, "_clr"}, 64'(set_clr), 64'd1);
            chk({tag, "_addr"}, 64'(set_addr), 64'(i));
            chk({tag, "_busy"}, 64'(cfg_busy), 64'd1);
            chk({tag, "_init"}, 64'(end_init_tcam), 64'(exp_init));
            @(posedge clk); #1;
        end
        chk({tag, "_done_valid"}, 64'(set_valid), 64'd0);
        chk({tag, "_done_busy"}, 64'(cfg_busy), 64'd0);
        chk({tag, "_done_init"}, 64'(end_init_tcam), 64'd1);
    endtask

    task automatic init_check();
        int k;
        k = 0;
        while (set_valid !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        sweep_check("init", 1'b0);
    endtask

    task automatic issue_check(input logic exp_clr, input logic [31:0] ea, input logic [31:0] ed,
                               input logic [63:0] ek, input logic [63:0] ex);
        chk("issue_valid", 64'(set_valid), 64'd1);
        chk("issue_clr", 64'(set_clr), 64'(exp_clr));
        chk("issue_addr", 64'(set_addr), 64'(ea));
        chk("issue_data", 64'(set_data), 64'(ed));
        chk("issue_key", 64'(set_key), ek);
        chk("issue_xmask", 64'(set_xmask), ex);
    endtask

    initial begin
        int          w;
        logic [31:0] d;
        logic [31:0] ea, ed;
        logic [63:0] ek, ex;

        rst_n = 1'b0; reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        reg_wr_addr = 16'h0; reg_wr_data = 32'h0; reg_wr_strb = 4'h0; reg_rd_addr = 16'h0;
        model_reset();
        #3;
        chk("rst_valid", 64'(set_valid), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_init", 64'(end_init_tcam), 64'd0);
        chk("rst_wr_ack", 64'(reg_wr_ack), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        init_check();

        // T2 directed commit
        wr(16'h08, 32'h3, 4'hF, w); model_write(2, 32'h3, 4'hF);
        wr(16'h0C, 32'h2, 4'hF, w); model_write(3, 32'h2, 4'hF);
        wr(16'h10, 32'hC0A8_0001, 4'hF, w); model_write(4, 32'hC0A8_0001, 4'hF);
        wr(16'h14, 32'h0000_0800, 4'hF, w); model_write(5, 32'h0000_0800, 4'hF);
        wr(16'h00, 32'h1, 4'hF, w); mcnt++;
        issue_check(1'b0, 32'h3, 32'h2, 64'h0800_C0A8_0001, 64'h0);
        @(posedge clk); #1;
        chk("t2_after_valid", 64'(set_valid), 64'd0);
        rd(16'h04, d);
        chk("t2_stat", 64'(d), 64'h0001_0002);

        // T5 byte strobes, masked widths and unmapped/WO reads
        wr(16'h10, 32'h1234_5678, 4'hF, w); model_write(4, 32'h1234_5678, 4'hF);
        wr(16'h10, 32'hFFFF_FFFF, 4'h3, w); model_write(4, 32'hFFFF_FFFF, 4'h3);
        rd(16'h10, d);
        chk("t5_key_lo", 64'(d), 64'h1234_FFFF);
        wr(16'h14, 32'hFFFF_FFFF, 4'hF, w); model_write(5, 32'hFFFF_FFFF, 4'hF);
        rd(16'h14, d);
        chk("t5_key_hi", 64'(d), 64'h0000_FFFF);
        rd(16'h00, d);
        chk("ctrl_read", 64'(d), 64'd0);
        wr(16'h40, 32'hDEAD_BEEF, 4'hF, w);
        rd(16'h40, d);
        chk("unmapped_read", 64'(d), 64'd0);

        // simultaneous read and write
        reg_wr_addr = 16'h0C; reg_wr_data = 32'h1; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
        reg_rd_addr = 16'h10; reg_rd_en = 1'b1;
        @(posedge clk); #1;
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        chk("simul_wr_ack", 64'(reg_wr_ack), 64'd1);
        chk("simul_rd_ack", 64'(reg_rd_ack), 64'd1);
        chk("simul_rd_data", 64'(reg_rd_data), 64'(mregs[4]));
        model_write(3, 32'h1, 4'hF);

        // T3 commit stalls behind a clear-all
        wr(16'h00, 32'h4, 4'hF, w);
        wr(16'h00, 32'h1, 4'hF, w); mcnt++;
        chk("t3_waits", 64'(w), 64'd16);
        issue_check(1'b0, mregs[2], mregs[3], {mregs[5], mregs[4]}, {mregs[7], mregs[6]});
        @(posedge clk); #1;
        rd(16'h04, d);
        chk("t3_stat", 64'(d), 64'(model_read(1)));

        // T4 all command bits: clear-all only
        wr(16'h00, 32'h7, 4'hF, w);
        sweep_check("t4", 1'b1);
        rd(16'h04, d);
        chk("t4_stat", 64'(d), 64'(model_read(1)));

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int          op;
            int          idx;
            int          cmd;
            logic [31:0] rdat;
            logic [3:0]  rs;
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                idx = $urandom_range(2, 8);
                rdat = $urandom;
                rs = 4'($urandom_range(0, 15));
                wr(16'(idx * 4), rdat, rs, w);
                model_write(idx, rdat, rs);
            end else if (op == 2) begin
                idx = $urandom_range(0, 8);
                rd(16'(idx * 4), d);
                chk("rand_read", 64'(d), 64'(model_read(idx)));
            end else begin
                cmd = $urandom_range(1, 3);
                ea = mregs[2]; ed = mregs[3];
                ek = {mregs[5], mregs[4]}; ex = {mregs[7], mregs[6]};
                wr(16'h00, 32'(cmd), 4'hF, w);
                if (cmd == 1) mcnt++;
                issue_check(cmd[1], ea, ed, ek, ex);
                rdat = $urandom;
                wr(16'h08, rdat, 4'hF, w);
                model_write(2, rdat, 4'hF);
                chk("rand_hold_valid", 64'(set_valid), 64'd0);
                chk("rand_hold_clr", 64'(set_clr), 64'd0);
                chk("rand_hold_addr", 64'(set_addr), 64'(ea));
            end
        end
        rd(16'h04, d);
        chk("rand_stat", 64'(d), 64'(model_read(1)));

        // T6 reset in the middle of a clear-all
        wr(16'h00, 32'h4, 4'hF, w);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_idx7", 64'(set_addr), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(set_valid), 64'd0);
        chk("t6_rst_clr", 64'(set_clr), 64'd0);
        chk("t6_rst_addr", 64'(set_addr), 64'd0);
        chk("t6_rst_busy", 64'(cfg_busy), 64'd0);
        chk("t6_rst_init", 64'(end_init_tcam), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        init_check();
        rd(16'h10, d);
        chk("t6_key_cleared", 64'(d), 64'd0);
        rd(16'h04, d);
        chk("t6_stat", 64'(d), 64'(model_read(1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
